// File: rtl/chip_port_pkg.sv
// chip_port_pkg: shared FSM state type, tristate polarity constants and a sizing helper
package chip_port_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam logic T_HIZ   = 1'b1;
    localparam logic T_DRIVE = 1'b0;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two register FIFO; head word is readable as soon as it is written
module sync_fifo #(
    parameter int DATA_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr, r_rd;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + ONE;
            if (i_pop) r_rd <= r_rd + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
    // extra pointer bit tells full from empty when the indices match
    assign o_data  = r_mem[r_rd[AW-1:0]];
    assign o_empty = r_wr == r_rd;
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
endmodule

// File: rtl/chip_output_port.sv
// chip_output_port: buffered pad driver with programmable setup/strobe/hold timing
// and an optional 4-phase acknowledge with timeout.
module chip_output_port
    import chip_port_pkg::*;
#(
    parameter int DATA_WIDTH    = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int ACK_MODE      = 0,
    parameter int ACK_TIMEOUT   = 255,
    parameter int PARK_HIZ      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] chip_data_o,
    output logic [DATA_WIDTH-1:0] chip_data_t,
    output logic                  data_ready_o,
    output logic                  data_ready_t,
    input  logic                  chip_ack,
    input  logic                  clear_err,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           words_sent
);
    localparam bit ACK  = ACK_MODE != 0;
    localparam bit PARK = PARK_HIZ != 0;
    localparam int CMAX = max2(max2(SETUP_CYCLES, STROBE_CYCLES), max2(HOLD_CYCLES, ACK_TIMEOUT));
    localparam int CW   = $clog2(CMAX + 1);
    localparam int HOLD_AT = ACK_TIMEOUT - HOLD_CYCLES;
    localparam logic [CW-1:0] L_SETUP  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] L_STROBE = CW'(ACK ? ACK_TIMEOUT - 1 : STROBE_CYCLES - 1);
    localparam logic [CW-1:0] L_HOLD   = CW'(ACK ? ACK_TIMEOUT - 1 : HOLD_CYCLES - 1);

    state_t r_state, w_next;
    logic [CW-1:0] r_cnt, w_load;
    logic [DATA_WIDTH-1:0] r_data, w_fifo_data;
    logic r_ack_meta, r_ack_s, r_err, r_fail;
    logic [15:0] r_sent;
    logic w_full, w_empty, w_push, w_pop, w_zero, w_hiz;
    logic w_strobe_done, w_strobe_to, w_hold_ok, w_hold_to;

    assign w_push = in_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && enable && !w_empty;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .i_push(w_push), .i_data(in_data), .i_pop(w_pop),
        .o_data(w_fifo_data), .o_full(w_full), .o_empty(w_empty)
    );

    // In ack mode the shared counter tracks the timeout; HOLD_AT marks when the hold time is met.
    assign w_zero        = r_cnt == '0;
    assign w_strobe_to   = ACK && !r_ack_s && w_zero;
    assign w_strobe_done = ACK ? (r_ack_s || w_zero) : w_zero;
    assign w_hold_ok     = ACK ? (int'(r_cnt) <= HOLD_AT && !r_ack_s) : w_zero;
    assign w_hold_to     = ACK && !w_hold_ok && w_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pop ? SETUP : IDLE;
            SETUP:   w_next = w_zero ? STROBE : SETUP;
            STROBE:  w_next = w_strobe_done ? HOLD : STROBE;
            HOLD:    w_next = (w_hold_ok || w_hold_to) ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
        w_load = (w_next == SETUP) ? L_SETUP : (w_next == STROBE) ? L_STROBE :
                 (w_next == HOLD) ? L_HOLD : '0;
    end

    always_comb begin
        w_hiz        = (r_state == IDLE) && PARK;
        data_ready_o = r_state == STROBE;
        data_ready_t = w_hiz ? T_HIZ : T_DRIVE;
        chip_data_t  = {DATA_WIDTH{w_hiz ? T_HIZ : T_DRIVE}};
        chip_data_o  = r_data;
        busy         = (r_state != IDLE) || !w_empty;
        in_ready     = !w_full;
        timeout_err  = r_err;
        words_sent   = r_sent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_data     <= '0;
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
            r_err      <= 1'b0;
            r_fail     <= 1'b0;
            r_sent     <= '0;
        end else begin
            r_ack_meta <= chip_ack;
            r_ack_s    <= r_ack_meta;
            if (w_next != r_state) r_cnt <= w_load;
            else if (!w_zero) r_cnt <= r_cnt - CW'(1);
            if (w_pop) r_data <= w_fifo_data;
            if (w_pop) r_fail <= 1'b0;
            else if (r_state == STROBE && w_strobe_to) r_fail <= 1'b1;
            if ((r_state == STROBE && w_strobe_to) || (r_state == HOLD && w_hold_to)) r_err <= 1'b1;
            else if (clear_err) r_err <= 1'b0;
            if (r_state == HOLD && w_hold_ok && !r_fail) r_sent <= r_sent + 16'd1;
        end
    end
endmodule

// File: tb/tb_chip_output_port.sv
// tb_chip_output_port: default port checked every cycle against a word-timeline model;
// ack-mode and driven-park instances checked with hand-derived timelines.
module tb_chip_output_port;
    localparam int S = 2, T = 4, H = 2, D = 4;

    logic clk = 0, reset = 1;
    logic a_valid = 0, a_enable = 1, a_ack = 0, a_clear = 0;
    logic b_valid = 0, b_enable = 1, b_ack = 0, b_clear = 0;
    logic c_valid = 0, c_enable = 1, c_ack = 0, c_clear = 0;
    logic [4:0] a_data = 0, b_data = 0, c_data = 0;
    logic a_in_ready, a_dr, a_dr_t, a_busy, a_err;
    logic b_in_ready, b_dr, b_dr_t, b_busy, b_err;
    logic c_in_ready, c_dr, c_dr_t, c_busy, c_err;
    logic [4:0] a_data_o, a_data_t, b_data_o, b_data_t, c_data_o, c_data_t;
    logic [15:0] a_words, b_words, c_words;

    int n_vec = 0, n_bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    chip_output_port u_dut (
        .clk(clk), .reset(reset), .enable(a_enable), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_in_ready), .chip_data_o(a_data_o), .chip_data_t(a_data_t),
        .data_ready_o(a_dr), .data_ready_t(a_dr_t), .chip_ack(a_ack), .clear_err(a_clear),
        .busy(a_busy), .timeout_err(a_err), .words_sent(a_words)
    );
    chip_output_port #(.ACK_MODE(1), .ACK_TIMEOUT(10)) u_ack (
        .clk(clk), .reset(reset), .enable(b_enable), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_in_ready), .chip_data_o(b_data_o), .chip_data_t(b_data_t),
        .data_ready_o(b_dr), .data_ready_t(b_dr_t), .chip_ack(b_ack), .clear_err(b_clear),
        .busy(b_busy), .timeout_err(b_err), .words_sent(b_words)
    );
    chip_output_port #(.PARK_HIZ(0)) u_park (
        .clk(clk), .reset(reset), .enable(c_enable), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_in_ready), .chip_data_o(c_data_o), .chip_data_t(c_data_t),
        .data_ready_o(c_dr), .data_ready_t(c_dr_t), .chip_ack(c_ack), .clear_err(c_clear),
        .busy(c_busy), .timeout_err(c_err), .words_sent(c_words)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: each popped word occupies S+T+H cycles after its pop edge, then one idle cycle.
    logic [4:0] mq[$];
    logic [4:0] mcur = 0;
    int mt = -1, msent = 0;
    bit m_push, m_pop;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mt = -1;
            mcur = 0;
            msent = 0;
        end else begin
            m_push = a_valid && (mq.size() < D);
            m_pop = (mt < 0) && a_enable && (mq.size() > 0);
            if (mt >= 0) begin
                mt++;
                if (mt == S + T + H) begin
                    mt = -1;
                    msent = (msent + 1) & 16'hffff;
                end
            end
            if (m_pop) begin
                mcur = mq.pop_front();
                mt = 0;
            end
            if (m_push) mq.push_back(a_data);
        end
    end

    always @(negedge clk) begin
        chk("cmp_in_ready", a_in_ready, mq.size() < D);
        chk("cmp_busy", a_busy, (mt >= 0) || (mq.size() > 0));
        chk("cmp_data_t", a_data_t, (mt < 0) ? 5'h1f : 5'h00);
        chk("cmp_data_o", a_data_o, mcur);
        chk("cmp_dr", a_dr, (mt >= S) && (mt < S + T));
        chk("cmp_dr_t", a_dr_t, mt < 0);
        chk("cmp_words", a_words, msent);
        chk("cmp_err", a_err, 0);
    end

    int rise_cyc[$];
    logic [4:0] rise_dat[$];
    logic prev_dr = 0;
    always @(negedge clk) begin
        if (a_dr && !prev_dr) begin
            rise_cyc.push_back(cyc);
            rise_dat.push_back(a_data_o);
        end
        prev_dr = a_dr;
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (a_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", a_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] w [6];
        int i, g;
        w = '{5'h01, 5'h1e, 5'h0b, 5'h14, 5'h07, 5'h19};
        tick(3);
        reset = 0;
        chk("rst_data_t", a_data_t, 5'h1f);
        chk("rst_dr_t", a_dr_t, 1);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_words", a_words, 0);
        chk("rst_park_data_t", c_data_t, 0);
        chk("rst_park_dr_t", c_dr_t, 0);

        // single word, default timing
        @(negedge clk); a_valid = 1; a_data = 5'h15;
        @(negedge clk); a_valid = 0;
        tick(1);
        chk("t1_drive", a_data_t, 0);
        chk("t1_data", a_data_o, 5'h15);
        chk("t1_setup_dr", a_dr, 0);
        tick(2); chk("t1_dr_rise", a_dr, 1);
        tick(3); chk("t1_dr_last", a_dr, 1);
        tick(1); chk("t1_dr_fall", a_dr, 0); chk("t1_hold_drive", a_data_t, 0);
        tick(1); chk("t1_hold2", a_busy, 1);
        tick(1);
        chk("t1_idle_hiz", a_data_t, 5'h1f);
        chk("t1_busy", a_busy, 0);
        chk("t1_words", a_words, 1);

        // six words back-to-back
        rise_cyc.delete(); rise_dat.delete();
        i = 0; g = 0;
        while (i < 6 && g < 100) begin
            @(negedge clk);
            g++;
            if (a_in_ready) begin
                a_valid = 1; a_data = w[i]; i++;
            end else a_valid = 0;
        end
        @(negedge clk); a_valid = 0;
        chk("t2_pushed", i, 6);
        wait_idle(150);
        chk("t2_strobes", rise_cyc.size(), 6);
        for (int k = 0; k < rise_dat.size() && k < 6; k++) begin
            chk("t2_order", rise_dat[k], w[k]);
            if (k > 0) chk("t2_period", rise_cyc[k] - rise_cyc[k-1], 1 + S + T + H);
        end
        chk("t2_words", a_words, 7);

        // reset during STROBE with two words queued
        @(negedge clk); a_valid = 1; a_data = 5'h03;
        @(negedge clk); a_data = 5'h0c;
        @(negedge clk); a_data = 5'h11;
        @(negedge clk); a_valid = 0;
        g = 0;
        while (!a_dr && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("t3_in_strobe", a_dr, 1);
        #2 reset = 1;
        #1;
        chk("t3_data_o", a_data_o, 0);
        chk("t3_data_t", a_data_t, 5'h1f);
        chk("t3_dr", a_dr, 0);
        chk("t3_dr_t", a_dr_t, 1);
        chk("t3_in_ready", a_in_ready, 1);
        chk("t3_busy", a_busy, 0);
        chk("t3_words", a_words, 0);
        tick(2);
        #2 reset = 0;
        rise_cyc.delete(); rise_dat.delete();
        tick(20);
        chk("t3_no_strobe", rise_cyc.size(), 0);
        chk("t3_idle", a_busy, 0);

        // ack mode: chip acks 3 cycles after rise, drops 2 cycles after fall
        @(negedge clk); b_valid = 1; b_data = 5'h07;
        @(negedge clk); b_valid = 0;
        tick(3); chk("t4_rise", b_dr, 1);
        tick(3); b_ack = 1;
        tick(2); chk("t4_still_high", b_dr, 1);
        tick(1); chk("t4_fall", b_dr, 0); chk("t4_hold_drive", b_data_t, 0);
        tick(2); b_ack = 0; chk("t4_hold_wait", b_busy, 1);
        tick(2); chk("t4_hold_wait2", b_busy, 1);
        tick(1);
        chk("t4_done", b_busy, 0);
        chk("t4_words", b_words, 1);
        chk("t4_err", b_err, 0);

        // ack mode timeout with ack held low
        @(negedge clk); b_valid = 1; b_data = 5'h1c;
        @(negedge clk); b_valid = 0;
        tick(3); chk("t5_rise", b_dr, 1);
        tick(9); chk("t5_high10", b_dr, 1); chk("t5_no_err_yet", b_err, 0);
        tick(1); chk("t5_fall", b_dr, 0); chk("t5_err", b_err, 1);
        tick(1); chk("t5_hold", b_busy, 1);
        tick(1);
        chk("t5_idle", b_busy, 0);
        chk("t5_words", b_words, 1);
        chk("t5_sticky", b_err, 1);
        b_clear = 1;
        tick(1); b_clear = 0;
        chk("t5_cleared", b_err, 0);

        // driven park, enable dropped during SETUP
        @(negedge clk); c_valid = 1; c_data = 5'h0a;
        @(negedge clk); c_data = 5'h13;
        @(negedge clk); c_valid = 0; c_enable = 0;
        chk("t6_first", c_data_o, 5'h0a);
        tick(8);
        chk("t6_done_dr", c_dr, 0);
        chk("t6_words", c_words, 1);
        chk("t6_queued", c_busy, 1);
        chk("t6_park_data", c_data_o, 5'h0a);
        chk("t6_park_t", c_data_t, 0);
        chk("t6_park_dr_t", c_dr_t, 0);
        tick(3);
        chk("t6_no_pop", c_data_o, 5'h0a);
        chk("t6_no_pop_busy", c_busy, 1);
        c_enable = 1;
        tick(1); chk("t6_second", c_data_o, 5'h13);
        tick(9);
        chk("t6_words2", c_words, 2);
        chk("t6_idle", c_busy, 0);
        chk("t6_park_last", c_data_o, 5'h13);
        chk("t6_park_t2", c_data_t, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
